// File: rtl/dlx_pkg.sv
// dlx_pkg: shared types for the DLX decode stage.
//   alu_op_e        ALU operation codes (0..15)
//   opcode_e        primary opcode values (instr[31:26])
//   funct_e         R-type function values (instr[5:0])
//   pc_cmd_e        PC-unit command encodings
//   pc_val_e        PC value source encodings
//   imm_kind_e      how the immediate is formed before widening to XLEN
//   decode_bundle_t width-independent control part of a decoded instruction
package dlx_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_BEQZ = 4'd8,
    ALU_BNEZ = 4'd9,
    ALU_SEQ  = 4'd10,
    ALU_SGE  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SNE  = 4'd13,
    ALU_SRA  = 4'd14,
    ALU_LINK = 4'd15
  } alu_op_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQZ  = 6'h04,
    OP_BNEZ  = 6'h05,
    OP_ADDI  = 6'h08,
    OP_SUBI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LHI   = 6'h0F,
    OP_JR    = 6'h12,
    OP_JALR  = 6'h13,
    OP_SLLI  = 6'h14,
    OP_SRLI  = 6'h16,
    OP_SRAI  = 6'h17,
    OP_SEQI  = 6'h18,
    OP_SNEI  = 6'h19,
    OP_SLTI  = 6'h1A,
    OP_SGEI  = 6'h1C,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h04,
    FN_SRL = 6'h06,
    FN_SRA = 6'h07,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_XOR = 6'h26,
    FN_SEQ = 6'h28,
    FN_SNE = 6'h29,
    FN_SLT = 6'h2A,
    FN_SGE = 6'h2C
  } funct_e;

  // 00 = sequential, 10 = pc-relative jump/branch, 11 = jump through register
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b10,
    PC_REG    = 2'b11
  } pc_cmd_e;

  typedef enum logic [1:0] {
    PV_NONE = 2'b00,
    PV_IMM  = 2'b01,
    PV_REG  = 2'b11
  } pc_val_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_S16  = 2'd1,
    IMM_Z16  = 2'd2,
    IMM_S26  = 2'd3
  } imm_kind_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    imm_sel;
    logic    pc_sel;
    pc_cmd_e pc_cmd;
    pc_val_e pc_val;
    logic    d_load_enable;
    logic    d_write_enable;
    logic    illegal;
  } decode_bundle_t;

endpackage

// File: rtl/dlx_decode_comb.sv
// dlx_decode_comb: purely combinational DLX instruction decoder.
//   instr  in   32      instruction word
//   ctrl   out  bundle  ALU/PC/memory controls and illegal flag
//   rs1    out  REG_AW  source register 1 (zero-extended field)
//   rs2    out  REG_AW  source register 2
//   rd     out  REG_AW  destination register
//   imm    out  XLEN    immediate widened to XLEN
module dlx_decode_comb
  import dlx_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  output decode_bundle_t    ctrl,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   imm
);

  logic [REG_AW-1:0] f_rs1, f_rs2, f_rd, f_link;
  imm_kind_e         imm_kind;

  assign f_rs1  = REG_AW'(instr[25:21]);
  assign f_rs2  = REG_AW'(instr[20:16]);
  assign f_rd   = REG_AW'(instr[15:11]);
  assign f_link = REG_AW'(5'd31);

  // Everything starts at zero so an undecoded word naturally becomes a NOP
  // bundle; only the illegal flag is raised on top of it.
  always_comb begin
    ctrl     = '0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    imm_kind = IMM_NONE;
    case (instr[31:26])
      OP_RTYPE: begin
        rs1 = f_rs1;
        rs2 = f_rs2;
        rd  = f_rd;
        case (instr[5:0])
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_SLL:  ctrl.alu_op = ALU_SLL;
          FN_SRL:  ctrl.alu_op = ALU_SRL;
          FN_SEQ:  ctrl.alu_op = ALU_SEQ;
          FN_SGE:  ctrl.alu_op = ALU_SGE;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SNE:  ctrl.alu_op = ALU_SNE;
          FN_SRA:  ctrl.alu_op = ALU_SRA;
          default: begin
            ctrl.illegal = 1'b1;
            rs1 = '0;
            rs2 = '0;
            rd  = '0;
          end
        endcase
      end
      OP_J, OP_JAL: begin
        ctrl.pc_cmd = PC_BRANCH;
        ctrl.pc_sel = 1'b1;
        ctrl.pc_val = PV_IMM;
        imm_kind    = IMM_S26;
        if (instr[31:26] == OP_JAL) begin
          ctrl.alu_op = ALU_LINK;
          rd          = f_link;
        end
      end
      default: begin
        // I-type base fields; individual opcodes override rd/rs2 below
        rs1          = f_rs1;
        rd           = f_rs2;
        ctrl.imm_sel = 1'b1;
        case (instr[31:26])
          OP_ADDI: begin ctrl.alu_op = ALU_ADD; imm_kind = IMM_S16; end
          OP_SUBI: begin ctrl.alu_op = ALU_SUB; imm_kind = IMM_S16; end
          OP_SEQI: begin ctrl.alu_op = ALU_SEQ; imm_kind = IMM_S16; end
          OP_SGEI: begin ctrl.alu_op = ALU_SGE; imm_kind = IMM_S16; end
          OP_SLTI: begin ctrl.alu_op = ALU_SLT; imm_kind = IMM_S16; end
          OP_SNEI: begin ctrl.alu_op = ALU_SNE; imm_kind = IMM_S16; end
          OP_ANDI: begin ctrl.alu_op = ALU_AND; imm_kind = IMM_Z16; end
          OP_ORI:  begin ctrl.alu_op = ALU_OR;  imm_kind = IMM_Z16; end
          OP_XORI: begin ctrl.alu_op = ALU_XOR; imm_kind = IMM_Z16; end
          OP_SLLI: begin ctrl.alu_op = ALU_SLL; imm_kind = IMM_Z16; end
          OP_SRLI: begin ctrl.alu_op = ALU_SRL; imm_kind = IMM_Z16; end
          OP_SRAI: begin ctrl.alu_op = ALU_SRA; imm_kind = IMM_Z16; end
          OP_LHI:  imm_kind = IMM_Z16;
          OP_LW: begin
            ctrl.alu_op        = ALU_ADD;
            imm_kind           = IMM_S16;
            ctrl.d_load_enable = 1'b1;
          end
          OP_SW: begin
            ctrl.alu_op         = ALU_ADD;
            imm_kind            = IMM_S16;
            rs2                 = f_rs2;
            rd                  = '0;
            ctrl.d_write_enable = 1'b1;
          end
          OP_BEQZ: begin
            ctrl.alu_op = ALU_BEQZ;
            imm_kind    = IMM_S16;
            ctrl.pc_cmd = PC_BRANCH;
          end
          OP_BNEZ: begin
            ctrl.alu_op = ALU_BNEZ;
            imm_kind    = IMM_S16;
            ctrl.pc_cmd = PC_BRANCH;
            rd          = '0;
          end
          OP_JR: begin
            ctrl.pc_cmd = PC_REG;
            ctrl.pc_val = PV_REG;
            rd          = '0;
          end
          OP_JALR: begin
            ctrl.alu_op = ALU_LINK;
            ctrl.pc_cmd = PC_REG;
            ctrl.pc_val = PV_REG;
            rd          = f_link;
          end
          default: begin
            ctrl     = '0;
            rs1      = '0;
            rd       = '0;
            imm_kind = IMM_NONE;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Widen the selected immediate field to the full datapath.
  always_comb begin
    case (imm_kind)
      IMM_S16: imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
      IMM_Z16: imm = {{(XLEN-16){1'b0}}, instr[15:0]};
      IMM_S26: imm = {{(XLEN-26){instr[25]}}, instr[25:0]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/dlx_decode_stage.sv
// dlx_decode_stage: pipelined DLX decode stage with valid/ready handshake.
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   drop every held entry and any same-cycle input
//   in_valid/in_ready       fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready     downstream handshake; out_pc plus decoded bundle
//   alu_op, rs1, rs2, rd, imm, imm_sel, pc_sel, pc_cmd, pc_val,
//   d_load_enable, d_write_enable, illegal   decoded bundle fields
// SKID=1 adds a second entry so in_ready can be a pure register output.
module dlx_decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   imm,
  output logic              imm_sel,
  output logic              pc_sel,
  output logic [1:0]        pc_cmd,
  output logic [1:0]        pc_val,
  output logic              d_load_enable,
  output logic              d_write_enable,
  output logic              illegal
);
  import dlx_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    decode_bundle_t    ctrl;
  } entry_t;

  decode_bundle_t    dec_ctrl;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_imm;
  entry_t            in_entry, out_q, skid_q;
  logic              out_valid_q, skid_valid;
  logic              in_fire, out_free, to_skid;

  dlx_decode_comb #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  assign in_entry = '{pc: in_pc, imm: dec_imm, rs1: dec_rs1, rs2: dec_rs2,
                      rd: dec_rd, ctrl: dec_ctrl};

  assign in_fire  = in_valid && in_ready;
  // The output slot can take a new entry when it is empty or being drained.
  assign out_free = !out_valid_q || out_ready;
  assign to_skid  = in_fire && !out_free;

  // Output register: the skid entry always has priority over fresh input so
  // the original order is kept; a stalled output holds its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
      end else if (in_fire) begin
        out_q       <= in_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      // ready_q mirrors !skid_valid one edge ahead, so it stays low out of
      // reset until the first clock edge after release.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          skid_valid <= 1'b0;
          skid_q     <= '0;
          ready_q    <= 1'b0;
        end else if (flush) begin
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else if (to_skid) begin
          skid_valid <= 1'b1;
          skid_q     <= in_entry;
          ready_q    <= 1'b0;
        end else if (skid_valid && out_free) begin
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else begin
          ready_q    <= !skid_valid;
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      logic ready_en;

      // Holds off acceptance until the first edge after reset release.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
      end

      assign skid_valid = 1'b0;
      assign skid_q     = '0;
      assign in_ready   = ready_en && out_free;
    end
  endgenerate

  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign alu_op         = out_q.ctrl.alu_op;
  assign rs1            = out_q.rs1;
  assign rs2            = out_q.rs2;
  assign rd             = out_q.rd;
  assign imm            = out_q.imm;
  assign imm_sel        = out_q.ctrl.imm_sel;
  assign pc_sel         = out_q.ctrl.pc_sel;
  assign pc_cmd         = out_q.ctrl.pc_cmd;
  assign pc_val         = out_q.ctrl.pc_val;
  assign d_load_enable  = out_q.ctrl.d_load_enable;
  assign d_write_enable = out_q.ctrl.d_write_enable;
  assign illegal        = out_q.ctrl.illegal;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// tb_dlx_decode_stage: scoreboard bench for dlx_decode_stage (XLEN=64, SKID=1).
// Expected bundles are computed by a reference decoder when an input
// transfer is seen and compared when the matching output transfer occurs.
module tb_dlx_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        imm_sel;
    logic        pc_sel;
    logic [1:0]  pc_cmd;
    logic [1:0]  pc_val;
    logic        dle;
    logic        dwe;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic        imm_sel, pc_sel;
  logic [1:0]  pc_cmd, pc_val;
  logic        d_load_enable, d_write_enable, illegal;

  int   n_total;
  int   n_bad;
  exp_t sb_q[$];
  exp_t act, want;
  logic [31:0] prog [15];

  dlx_decode_stage #(.XLEN(64), .REG_AW(5), .SKID(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .alu_op         (alu_op),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .imm            (imm),
    .imm_sel        (imm_sel),
    .pc_sel         (pc_sel),
    .pc_cmd         (pc_cmd),
    .pc_val         (pc_val),
    .d_load_enable  (d_load_enable),
    .d_write_enable (d_write_enable),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: opcode tables give (alu op, immediate kind),
  // then per-opcode side effects are layered on.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    logic [5:0] op, fn;
    int a, k;
    bit known;
    e = '0;
    e.pc = pc;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: a = 1;   6'h22: a = 2;   6'h24: a = 3;   6'h25: a = 4;
        6'h26: a = 5;   6'h04: a = 6;   6'h06: a = 7;   6'h28: a = 10;
        6'h2C: a = 11;  6'h2A: a = 12;  6'h29: a = 13;  6'h07: a = 14;
        default: a = -1;
      endcase
      if (a < 0) e.ill = 1'b1;
      else begin
        e.alu_op = a[3:0];
        e.rs1 = w[25:21];
        e.rs2 = w[20:16];
        e.rd  = w[15:11];
      end
    end else if (op == 6'h02 || op == 6'h03) begin
      e.pc_cmd = 2'b10;
      e.pc_sel = 1'b1;
      e.pc_val = 2'b01;
      e.imm    = {{38{w[25]}}, w[25:0]};
      if (op == 6'h03) begin
        e.alu_op = 4'd15;
        e.rd     = 5'd31;
      end
    end else begin
      known = 1'b1;
      k = 0;
      a = 0;
      case (op)
        6'h08: begin a = 1;  k = 1; end
        6'h0A: begin a = 2;  k = 1; end
        6'h18: begin a = 10; k = 1; end
        6'h1C: begin a = 11; k = 1; end
        6'h1A: begin a = 12; k = 1; end
        6'h19: begin a = 13; k = 1; end
        6'h0C: begin a = 3;  k = 2; end
        6'h0D: begin a = 4;  k = 2; end
        6'h0E: begin a = 5;  k = 2; end
        6'h14: begin a = 6;  k = 2; end
        6'h16: begin a = 7;  k = 2; end
        6'h17: begin a = 14; k = 2; end
        6'h0F: begin a = 0;  k = 2; end
        6'h23: begin a = 1;  k = 1; end
        6'h2B: begin a = 1;  k = 1; end
        6'h04: begin a = 8;  k = 1; end
        6'h05: begin a = 9;  k = 1; end
        6'h12: begin a = 0;  k = 0; end
        6'h13: begin a = 15; k = 0; end
        default: known = 1'b0;
      endcase
      if (!known) e.ill = 1'b1;
      else begin
        e.rs1     = w[25:21];
        e.rd      = w[20:16];
        e.imm_sel = 1'b1;
        e.alu_op  = a[3:0];
        if (k == 1) e.imm = {{48{w[15]}}, w[15:0]};
        if (k == 2) e.imm = {48'd0, w[15:0]};
        if (op == 6'h23) e.dle = 1'b1;
        if (op == 6'h2B) begin e.rs2 = w[20:16]; e.rd = 5'd0; e.dwe = 1'b1; end
        if (op == 6'h04 || op == 6'h05) e.pc_cmd = 2'b10;
        if (op == 6'h05) e.rd = 5'd0;
        if (op == 6'h12 || op == 6'h13) begin e.pc_cmd = 2'b11; e.pc_val = 2'b11; end
        if (op == 6'h12) e.rd = 5'd0;
        if (op == 6'h13) e.rd = 5'd31;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle: pop on output transfer,
  // push the model result on input transfer, forget everything on flush/reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_total++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL unexpected_output: got out_pc=%h with empty scoreboard, want no output", out_pc);
        end else begin
          want = sb_q.pop_front();
          act.pc = out_pc;        act.imm = imm;         act.alu_op = alu_op;
          act.rs1 = rs1;          act.rs2 = rs2;         act.rd = rd;
          act.imm_sel = imm_sel;  act.pc_sel = pc_sel;   act.pc_cmd = pc_cmd;
          act.pc_val = pc_val;    act.dle = d_load_enable;
          act.dwe = d_write_enable; act.ill = illegal;
          if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL bundle pc=%h: got %h want %h", want.pc, act, want);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_pc));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer one instruction and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    bit took;
    took = 1'b0;
    in_instr = w;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_total++;
    if (!took) begin
      n_bad++;
      $display("[TB] FAIL accept_timeout pc=%h: got in_ready=0 for 20 cycles, want accept", pc);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    @(posedge clk);
    #1;
    n_total++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready, alu_op, rd, imm, out_pc, illegal, pc_cmd} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b alu=%0d rd=%0d imm=%h pc=%h ill=%b, want all 0",
               out_valid, in_ready, alu_op, rd, imm, out_pc, illegal);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ready_before_edge: got in_ready=%b, want 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL ready_after_edge: got in_ready=%b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(32'h00A41020, 64'h0);
    @(negedge clk);
    n_total++;
    if ({out_valid, alu_op, rs1, rs2, rd, imm_sel} !== {1'b1, 4'd1, 5'd5, 5'd4, 5'd2, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL add: got v=%b alu=%0d rs1=%0d rs2=%0d rd=%0d isel=%b, want 1 1 5 4 2 0",
               out_valid, alu_op, rs1, rs2, rd, imm_sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi_xlen64();
    out_ready = 1'b1;
    send(32'h2023FFFC, 64'h4);
    @(negedge clk);
    n_total++;
    if ({imm, rd, rs1, imm_sel, alu_op} !== {64'hFFFF_FFFF_FFFF_FFFC, 5'd3, 5'd1, 1'b1, 4'd1}) begin
      n_bad++;
      $display("[TB] FAIL addi: got imm=%h rd=%0d rs1=%0d isel=%b alu=%0d, want fffffffffffffffc 3 1 1 1",
               imm, rd, rs1, imm_sel, alu_op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_jal();
    out_ready = 1'b1;
    send(32'h0E000010, 64'h8);
    @(negedge clk);
    n_total++;
    if ({pc_cmd, pc_val, pc_sel, alu_op, rd, imm} !== {2'b10, 2'b01, 1'b1, 4'd15, 5'd31, 64'hFFFF_FFFF_FE00_0010}) begin
      n_bad++;
      $display("[TB] FAIL jal: got cmd=%b val=%b psel=%b alu=%0d rd=%0d imm=%h, want 10 01 1 15 31 fffffffffe000010",
               pc_cmd, pc_val, pc_sel, alu_op, rd, imm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = prog[i];
      in_pc    = 64'h1000 + 64'(4 * i);
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL throughput step %0d: got in_ready=%b, want 1", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] items [3];
    logic [7:0]  rdy_pat, exp_rdy;
    int idx;
    items[0] = 32'h00A41020;
    items[1] = 32'h8CA4FFF8;
    items[2] = 32'hACA40010;
    rdy_pat  = 8'b1111_0000;
    exp_rdy  = 8'b1110_0011;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      out_ready = rdy_pat[cyc];
      if (idx < 3) begin
        in_valid = 1'b1;
        in_instr = items[idx];
        in_pc    = 64'h100 + 64'(4 * idx);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_total++;
      if (in_ready !== exp_rdy[cyc]) begin
        n_bad++;
        $display("[TB] FAIL stall_ready cycle %0d: got in_ready=%b, want %b", cyc, in_ready, exp_rdy[cyc]);
      end
      if (cyc >= 1 && cyc <= 3) begin
        n_total++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL stall_hold cycle %0d: got empty scoreboard, want entry A pending", cyc);
        end else if ({out_valid, out_pc, alu_op, rd, d_load_enable} !==
                     {1'b1, sb_q[0].pc, sb_q[0].alu_op, sb_q[0].rd, sb_q[0].dle}) begin
          n_bad++;
          $display("[TB] FAIL stall_hold cycle %0d: got v=%b pc=%h alu=%0d rd=%0d, want 1 %h %0d %0d",
                   cyc, out_valid, out_pc, alu_op, rd, sb_q[0].pc, sb_q[0].alu_op, sb_q[0].rd);
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'hFC000000, 64'h200);
    @(negedge clk);
    n_total++;
    if ({illegal, alu_op, rd, d_load_enable, d_write_enable, pc_cmd} !== {1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("[TB] FAIL illegal_op: got ill=%b alu=%0d rd=%0d le=%b we=%b, want 1 0 0 0 0",
               illegal, alu_op, rd, d_load_enable, d_write_enable);
    end
    @(posedge clk);
    #1;
    send(32'h00A4103F, 64'h204);
    @(negedge clk);
    n_total++;
    if ({illegal, alu_op, rd, rs1, d_load_enable, d_write_enable} !== {1'b1, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL illegal_funct: got ill=%b alu=%0d rd=%0d rs1=%0d le=%b we=%b, want 1 0 0 0 0 0",
               illegal, alu_op, rd, rs1, d_load_enable, d_write_enable);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_backpressure();
    int sent, cyc;
    bit took;
    sent = 0;
    cyc  = 0;
    in_instr = prog[$urandom_range(0, 14)];
    in_pc    = 64'h3000;
    in_valid = 1'b1;
    while (sent < 20 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        sent++;
        in_instr = prog[$urandom_range(0, 14)];
        in_pc    = 64'h3000 + 64'(4 * sent);
        if (sent >= 20) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_total++;
    if (sent != 20) begin
      n_bad++;
      $display("[TB] FAIL random_timeout: got %0d accepted, want 20", sent);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00A41022, 64'h400);
    send(32'h8CA4FFF8, 64'h404);
    in_valid = 1'b1;
    in_instr = 32'h00A41020;
    in_pc    = 64'h408;
    flush    = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL flush_pre: got out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL flush_post: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h2023FFFC, 64'h40C);
    @(negedge clk);
    n_total++;
    if ({out_valid, out_pc, alu_op, rd} !== {1'b1, 64'h40C, 4'd1, 5'd3}) begin
      n_bad++;
      $display("[TB] FAIL flush_recover: got v=%b pc=%h alu=%0d rd=%0d, want 1 40c 1 3",
               out_valid, out_pc, alu_op, rd);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    send(32'h00A41020, 64'h500);
    #2;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stall_before_reset: got out_valid=%b, want 1", out_valid);
    end
    reset_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got out_valid=%b, want 0", out_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'h08000100, 64'h600);
    drain();
  endtask

  initial begin
    prog = '{32'h00A41022, 32'h00A4102A, 32'h00A41007, 32'h30A48001, 32'h68A48000,
             32'h3C041234, 32'h8CA4FFF8, 32'hACA40010, 32'h10A0FFF0, 32'h14A00020,
             32'h48A00000, 32'h4CA00000, 32'h08000100, 32'h5CA40003, 32'h70A4FFFF};
    n_total   = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_addi_xlen64();
    test_jal();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_random_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
